zap_multiply_long: RTL and testbench
====================================

Name: zap_multiply_long

Overview:
- Parametrised successor to the shift stage's 32x32+32 multiply-accumulate helper.
- Iterative signed/unsigned multiplier with optional accumulate, covering MUL, MLA, UMULL, SMULL, UMLAL and SMLAL.
- Produces a 2*WIDTH-bit result and N/Z flags.
- Sits beside the barrel shifter. The shift stage stalls on o_busy and captures results on o_done.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of DIGIT_BITS.
- DIGIT_BITS, 8: multiplier bits consumed per MULT cycle; one of 1, 2, 4, 8, 16 or 32. N = WIDTH/DIGIT_BITS.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous abort (pipeline flush).
- i_start  in  1  start request; sampled only in IDLE.
- i_signed  in  1  operands are two's complement.
- i_long  in  1  1 = 2*WIDTH result; 0 = WIDTH result.
- i_accumulate  in  1  add {i_rn_hi, i_rn_lo} to the product.
- i_rm  in  WIDTH  multiplicand.
- i_rs  in  WIDTH  multiplier.
- i_rn_lo  in  WIDTH  accumulator, low half.
- i_rn_hi  in  WIDTH  accumulator, high half; ignored when i_long=0.
- o_rd_lo  out  WIDTH  result, low half.
- o_rd_hi  out  WIDTH  result, high half.
- o_n  out  1  result MSB.
- o_z  out  1  result is zero.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse; results valid.

Behaviour:
- Reset:
  - Asserting i_reset_n=0 immediately forces state=IDLE and clears all outputs and internal registers to 0.
  - Takes effect mid-operation with no completion.
- States: IDLE, MULT, SIGN, ACC, DONE.
- IDLE:
  - If i_start=1 and i_clear=0, latch every operand and mode input.
  - Convert rm and rs to magnitudes if i_signed. Record neg = signed & (rm MSB XOR rs MSB).
  - Clear the 2*WIDTH-bit partial product. Go to MULT with digit counter=0.
- MULT:
  - Each cycle: partial += |rm| * (next DIGIT_BITS bits of |rs|, LSB first), shifted by counter*DIGIT_BITS.
  - Counter increments. After N cycles go to SIGN.
- SIGN: if neg, partial = two's complement of partial (2*WIDTH bits). Go to ACC.
- ACC:
  - If i_accumulate, partial += {rn_hi, rn_lo}, with rn_hi treated as 0 when i_long=0.
  - Arithmetic wraps modulo 2^(2*WIDTH). Go to DONE.
- DONE:
  - Register outputs: o_rd_lo = partial[WIDTH-1:0].
  - o_rd_hi = partial[2W-1:W] if i_long, else 0.
  - o_n = MSB of o_rd_hi if long, else MSB of o_rd_lo.
  - o_z = (selected result == 0).
  - o_done=1 for exactly this cycle, then return to IDLE.
- Timing:
  - Start sampled at edge k: o_busy=1 during cycles k+1 .. k+N+2; o_busy=0 and o_done=1 in cycle k+N+3.
  - Default parameters (N=4): done at k+7.
- Output hold: o_rd_lo, o_rd_hi, o_n and o_z hold their values until the next DONE, a clear, or reset.
- i_start while busy is ignored; no queueing.
- i_clear:
  - In any state: go to IDLE next edge; o_busy=0, o_done=0; result outputs hold their values.
  - i_clear together with i_start in IDLE: clear wins and the start is dropped.
- Signed boundary case: rm = most negative value. Its magnitude is 2^(WIDTH-1), held in WIDTH bits unsigned, and the result is correct.

Optional Feature:
- Macro: ZAP_MULT_EARLY_TERM_EN.
- Defined:
  - In MULT, if all remaining unconsumed bits of |rs| are zero after the current digit, go directly to SIGN.
  - Latency becomes k + (digits used) + 3, with a minimum of one MULT cycle. |rs| = 0 takes one MULT cycle.
  - Results are identical to the fixed-latency build.
- Not defined: fixed latency of N MULT cycles always.

Test Plan (WIDTH=32, DIGIT_BITS=8):
- UMULL: rm=rs=0xFFFFFFFF, start at k -> rd_hi=0xFFFFFFFE, rd_lo=0x00000001, n=1, z=0, o_done at k+7, o_busy high k+1..k+6.
- SMULL: rm=0xFFFFFFFE, rs=3 -> rd_hi=0xFFFFFFFF, rd_lo=0xFFFFFFFA, n=1.
- SMULL: rm=0x80000000, rs=0x80000000 -> rd_hi=0x40000000, rd_lo=0, n=0.
- UMLAL: rm=2, rs=3, rn_hi=0, rn_lo=0xFFFFFFFF -> rd_hi=1, rd_lo=5.
- Short MLA: rm=rs=0x10000, rn_lo=0, i_long=0 -> rd_lo=0, rd_hi=0, z=1.
- Clear: i_clear at k+3 -> o_busy=0 at k+4, no o_done pulse, previous results unchanged.
  - i_start pulsed at k+2 is ignored.
  - i_clear and i_start together in IDLE -> no operation starts.
- Reset and early termination:
  - i_reset_n low at k+2 -> all outputs 0 immediately; after release, a fresh start completes normally.
  - With ZAP_MULT_EARLY_TERM_EN and rs=1: done at k+4, result correct. Without the macro: done at k+7.

Source files
------------

// File: rtl/zap_multiply_long_if.sv
`default_nettype none
// ============================================================================
// Module      : zap_multiply_long_if
// Description : Operand/mode/result bundle between the shift stage and the
//               iterative long multiplier. The shift stage holds the master
//               side. The multiplier holds the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface zap_multiply_long_if #(
    parameter int WIDTH = 32
);
    // Request side (driven by the shift stage)
    logic             i_clear;
    logic             i_start;
    logic             i_signed;
    logic             i_long;
    logic             i_accumulate;
    logic [WIDTH-1:0] i_rm;
    logic [WIDTH-1:0] i_rs;
    logic [WIDTH-1:0] i_rn_lo;
    logic [WIDTH-1:0] i_rn_hi;

    // Result side (driven by the multiplier)
    logic [WIDTH-1:0] o_rd_lo;
    logic [WIDTH-1:0] o_rd_hi;
    logic             o_n;
    logic             o_z;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_clear, i_start, i_signed, i_long, i_accumulate,
        output i_rm, i_rs, i_rn_lo, i_rn_hi,
        input  o_rd_lo, o_rd_hi, o_n, o_z, o_busy, o_done
    );

    modport slave (
        input  i_clear, i_start, i_signed, i_long, i_accumulate,
        input  i_rm, i_rs, i_rn_lo, i_rn_hi,
        output o_rd_lo, o_rd_hi, o_n, o_z, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/zap_multiply_long.sv
`default_nettype none
// ============================================================================
// Module      : zap_multiply_long
// Description : Iterative signed/unsigned multiply with optional accumulate
//               (MUL, MLA, UMULL, SMULL, UMLAL, SMLAL). The magnitude of the
//               multiplier is consumed DIGIT_BITS bits per MULT cycle. The
//               sign is applied once in SIGN. The accumulator is added in ACC.
//               A 2*WIDTH-bit result and N/Z flags are registered on entry
//               to DONE.
//               Optional macro ZAP_MULT_EARLY_TERM_EN: leave MULT as soon as
//               no non-zero multiplier digits remain.
// Revision    : 1.0 - initial release
// ============================================================================
module zap_multiply_long #(
    parameter int WIDTH      = 32,
    parameter int DIGIT_BITS = 8
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset_n,
    zap_multiply_long_if.slave     mul_if
);

    localparam int N     = WIDTH / DIGIT_BITS;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_SIGN = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]      partial_q, partial_d;
    // Multiplicand magnitude, pre-shifted left by DIGIT_BITS every MULT
    // cycle so that each digit's product lands at the right weight.
    logic [PW-1:0]      mcand_q,   mcand_d;
    // Multiplier magnitude, shifted right by DIGIT_BITS every MULT cycle.
    // The current digit is always in the low bits.
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic               neg_q,     neg_d;
    logic               long_q,    long_d;
    logic               acc_q,     acc_d;
    logic [WIDTH-1:0]   rn_lo_q,   rn_lo_d;
    logic [WIDTH-1:0]   rn_hi_q,   rn_hi_d;

    // Registered outputs
    logic [WIDTH-1:0]   rd_lo_q,   rd_lo_d;
    logic [WIDTH-1:0]   rd_hi_q,   rd_hi_d;
    logic               n_q,       n_d;
    logic               z_q,       z_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_rm_neg;
    logic               w_rs_neg;
    logic [WIDTH-1:0]   w_rm_mag;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [DIGIT_BITS-1:0] w_digit;
    logic [PW-1:0]      w_term;
    logic [WIDTH-1:0]   w_mplier_rest;
    logic               w_mult_last;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_sum;

    // Operand magnitudes and the sign of the final product. The most
    // negative value negates to itself. Read as unsigned, that bit pattern
    // is exactly 2^(WIDTH-1), so no extra width is needed.
    always_comb begin
        w_rm_neg = mul_if.i_signed & mul_if.i_rm[WIDTH-1];
        w_rs_neg = mul_if.i_signed & mul_if.i_rs[WIDTH-1];
        w_rm_mag = w_rm_neg ? ({WIDTH{1'b0}} - mul_if.i_rm) : mul_if.i_rm;
        w_rs_mag = w_rs_neg ? ({WIDTH{1'b0}} - mul_if.i_rs) : mul_if.i_rs;
    end

    // One digit-by-multiplicand partial product per MULT cycle, plus the exit test
    always_comb begin
        w_digit       = mplier_q[DIGIT_BITS-1:0];
        w_term        = mcand_q * {{(PW-DIGIT_BITS){1'b0}}, w_digit};
        w_mplier_rest = mplier_q >> DIGIT_BITS;
`ifdef ZAP_MULT_EARLY_TERM_EN
        // Nothing left to add once the remaining multiplier bits are all zero
        w_mult_last   = (cnt_q == CNT_W'(N - 1)) || (w_mplier_rest == {WIDTH{1'b0}});
`else
        w_mult_last   = (cnt_q == CNT_W'(N - 1));
`endif
    end

    // Accumulator operand; the high half only takes part in long operations
    always_comb begin
        w_addend = {PW{1'b0}};
        if (acc_q) begin
            w_addend = {(long_q ? rn_hi_q : {WIDTH{1'b0}}), rn_lo_q};
        end
        w_sum = partial_q + w_addend;
    end

    // Next-state and next-register computation for the whole sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        long_d    = long_q;
        acc_d     = acc_q;
        rn_lo_d   = rn_lo_q;
        rn_hi_d   = rn_hi_q;
        rd_lo_d   = rd_lo_q;
        rd_hi_d   = rd_hi_q;
        n_d       = n_q;
        z_d       = z_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (mul_if.i_clear) begin
            // Flush: abandon any operation, keep the last published result
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mul_if.i_start) begin
                        mcand_d   = {{WIDTH{1'b0}}, w_rm_mag};
                        mplier_d  = w_rs_mag;
                        neg_d     = w_rm_neg ^ w_rs_neg;
                        long_d    = mul_if.i_long;
                        acc_d     = mul_if.i_accumulate;
                        rn_lo_d   = mul_if.i_rn_lo;
                        rn_hi_d   = mul_if.i_rn_hi;
                        partial_d = {PW{1'b0}};
                        cnt_d     = {CNT_W{1'b0}};
                        busy_d    = 1'b1;
                        state_d   = S_MULT;
                    end
                end

                S_MULT: begin
                    partial_d = partial_q + w_term;
                    mcand_d   = mcand_q << DIGIT_BITS;
                    mplier_d  = w_mplier_rest;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (w_mult_last) begin
                        state_d = S_SIGN;
                    end
                end

                S_SIGN: begin
                    if (neg_q) begin
                        partial_d = {PW{1'b0}} - partial_q;
                    end
                    state_d = S_ACC;
                end

                S_ACC: begin
                    // Result registers load here so they are valid while in DONE
                    partial_d = w_sum;
                    rd_lo_d   = w_sum[WIDTH-1:0];
                    rd_hi_d   = long_q ? w_sum[PW-1:WIDTH] : {WIDTH{1'b0}};
                    n_d       = long_q ? w_sum[PW-1] : w_sum[WIDTH-1];
                    z_d       = long_q ? (w_sum == {PW{1'b0}})
                                       : (w_sum[WIDTH-1:0] == {WIDTH{1'b0}});
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // All state, datapath and output flops; reset wipes everything immediately
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            partial_q <= {PW{1'b0}};
            mcand_q   <= {PW{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            neg_q     <= 1'b0;
            long_q    <= 1'b0;
            acc_q     <= 1'b0;
            rn_lo_q   <= {WIDTH{1'b0}};
            rn_hi_q   <= {WIDTH{1'b0}};
            rd_lo_q   <= {WIDTH{1'b0}};
            rd_hi_q   <= {WIDTH{1'b0}};
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            long_q    <= long_d;
            acc_q     <= acc_d;
            rn_lo_q   <= rn_lo_d;
            rn_hi_q   <= rn_hi_d;
            rd_lo_q   <= rd_lo_d;
            rd_hi_q   <= rd_hi_d;
            n_q       <= n_d;
            z_q       <= z_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mul_if.o_rd_lo = rd_lo_q;
    assign mul_if.o_rd_hi = rd_hi_q;
    assign mul_if.o_n     = n_q;
    assign mul_if.o_z     = z_q;
    assign mul_if.o_busy  = busy_q;
    assign mul_if.o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_zap_multiply_long.sv
`default_nettype none
// ============================================================================
// Module      : tb_zap_multiply_long
// Description : Self-checking bench for zap_multiply_long. Expected results
//               come from a 64-bit arithmetic model and go through a
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_multiply_long;

    localparam int WIDTH      = 32;
    localparam int DIGIT_BITS = 8;
    localparam int N          = WIDTH / DIGIT_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    zap_multiply_long_if #(.WIDTH(WIDTH)) mul_if ();

    zap_multiply_long #(.WIDTH(WIDTH), .DIGIT_BITS(DIGIT_BITS)) u_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .mul_if    (mul_if)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        n;
        logic        z;
    } res_t;

    res_t sb_q[$];
    res_t last_res;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: sign/zero-extend to 64 bits, multiply, add, then select
    function automatic res_t model(input logic sg, input logic lg, input logic ac,
                                   input logic [31:0] rm, input logic [31:0] rs,
                                   input logic [31:0] rl, input logic [31:0] rh);
        logic [63:0] a, b, p;
        res_t r;
        a = sg ? {{32{rm[31]}}, rm} : {32'h0, rm};
        b = sg ? {{32{rs[31]}}, rs} : {32'h0, rs};
        p = a * b;
        if (ac) p = p + {(lg ? rh : 32'h0), rl};
        r.lo = p[31:0];
        r.hi = lg ? p[63:32] : 32'h0;
        r.n  = lg ? p[63] : p[31];
        r.z  = lg ? (p == 64'h0) : (p[31:0] == 32'h0);
        return r;
    endfunction

    function automatic int exp_latency(input logic sg, input logic [31:0] rs);
        int lat;
        lat = N + 3;
`ifdef ZAP_MULT_EARLY_TERM_EN
        begin
            logic [31:0] m;
            int used;
            m    = (sg && rs[31]) ? (32'h0 - rs) : rs;
            used = 1;
            for (int i = 0; i < N; i++) begin
                if (((m >> (i * DIGIT_BITS)) & 32'hFF) != 32'h0) used = i + 1;
            end
            lat = used + 3;
        end
`endif
        return lat;
    endfunction

    task automatic drive_op(input logic sg, input logic lg, input logic ac,
                            input logic [31:0] rm, input logic [31:0] rs,
                            input logic [31:0] rl, input logic [31:0] rh);
        mul_if.i_signed     = sg;
        mul_if.i_long       = lg;
        mul_if.i_accumulate = ac;
        mul_if.i_rm         = rm;
        mul_if.i_rs         = rs;
        mul_if.i_rn_lo      = rl;
        mul_if.i_rn_hi      = rh;
        mul_if.i_start      = 1'b1;
    endtask

    // Full operation: push expectation, start, track busy, pop on done
    task automatic do_op(input string tag, input logic sg, input logic lg, input logic ac,
                         input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] rl, input logic [31:0] rh);
        int   cyc;
        int   lat;
        res_t exp_r;
        lat = exp_latency(sg, rs);
        @(negedge clk);
        drive_op(sg, lg, ac, rm, rs, rl, rh);
        sb_q.push_back(model(sg, lg, ac, rm, rs, rl, rh));
        @(posedge clk);
        #1 mul_if.i_start = 1'b0;
        cyc = 1;
        while (!mul_if.o_done && cyc < 40) begin
            check({tag, "_busy"}, {63'h0, mul_if.o_busy}, 64'h1);
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!mul_if.o_done) begin
            check({tag, "_timeout"}, 64'h0, 64'h1);
            void'(sb_q.pop_front());
        end else begin
            check({tag, "_latency"}, 64'(cyc), 64'(lat));
            check({tag, "_busy_at_done"}, {63'h0, mul_if.o_busy}, 64'h0);
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'h0, 64'h1);
            end else begin
                exp_r = sb_q.pop_front();
                check({tag, "_hi"}, {32'h0, mul_if.o_rd_hi}, {32'h0, exp_r.hi});
                check({tag, "_lo"}, {32'h0, mul_if.o_rd_lo}, {32'h0, exp_r.lo});
                check({tag, "_nz"}, {62'h0, mul_if.o_n, mul_if.o_z}, {62'h0, exp_r.n, exp_r.z});
                last_res = exp_r;
            end
            @(posedge clk);
            #1 check({tag, "_done_pulse"}, {63'h0, mul_if.o_done}, 64'h0);
        end
    endtask

    task automatic check_outputs_held(input string tag);
        check({tag, "_hi"}, {32'h0, mul_if.o_rd_hi}, {32'h0, last_res.hi});
        check({tag, "_lo"}, {32'h0, mul_if.o_rd_lo}, {32'h0, last_res.lo});
        check({tag, "_nz"}, {62'h0, mul_if.o_n, mul_if.o_z}, {62'h0, last_res.n, last_res.z});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        mul_if.i_clear      = 1'b0;
        mul_if.i_start      = 1'b0;
        mul_if.i_signed     = 1'b0;
        mul_if.i_long       = 1'b0;
        mul_if.i_accumulate = 1'b0;
        mul_if.i_rm         = 32'h0;
        mul_if.i_rs         = 32'h0;
        mul_if.i_rn_lo      = 32'h0;
        mul_if.i_rn_hi      = 32'h0;
        last_res            = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_lo_hi", {mul_if.o_rd_hi, mul_if.o_rd_lo}, 64'h0);
        check("reset_flags", {60'h0, mul_if.o_n, mul_if.o_z, mul_if.o_busy, mul_if.o_done}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations
        do_op("umull_max",  1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
        do_op("smull_neg",  1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0);
        do_op("smull_min",  1'b1, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h0, 32'h0);
        do_op("umlal_cy",   1'b0, 1'b1, 1'b1, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 32'h0);
        do_op("mla_short",  1'b0, 1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'h0, 32'h12345678);
        do_op("smlal_neg",  1'b1, 1'b1, 1'b1, 32'h80000000, 32'h00000001, 32'h00000005, 32'hFFFFFFFF);
        do_op("mul_rs1",    1'b0, 1'b0, 1'b0, 32'h89ABCDEF, 32'h00000001, 32'h0, 32'h0);
        do_op("mul_rs0",    1'b1, 1'b1, 1'b0, 32'h89ABCDEF, 32'h00000000, 32'h0, 32'h0);

        // Clear mid-operation; a start while busy is ignored
        @(negedge clk);
        drive_op(1'b0, 1'b1, 1'b0, 32'h11111111, 32'hFFFFFFFF, 32'h0, 32'h0);
        @(posedge clk);                          // edge k
        #1 mul_if.i_start = 1'b0;
        @(posedge clk);                          // edge k+1
        @(negedge clk);
        drive_op(1'b0, 1'b1, 1'b0, 32'h3, 32'h3, 32'h0, 32'h0);
        @(posedge clk);                          // edge k+2, ignored start
        #1 mul_if.i_start = 1'b0;
        @(negedge clk);
        mul_if.i_clear = 1'b1;
        @(posedge clk);                          // edge k+3
        #1 check("clr_busy", {63'h0, mul_if.o_busy}, 64'h0);
        @(negedge clk);
        mul_if.i_clear = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (mul_if.o_done || mul_if.o_busy) dones++;
        end
        check("clr_no_done", 64'(dones), 64'h0);
        check_outputs_held("clr_hold");

        // Clear and start together in IDLE: nothing starts
        @(negedge clk);
        drive_op(1'b0, 1'b1, 1'b0, 32'h5, 32'h7, 32'h0, 32'h0);
        mul_if.i_clear = 1'b1;
        @(posedge clk);
        #1;
        mul_if.i_start = 1'b0;
        mul_if.i_clear = 1'b0;
        check("clrstart_busy", {63'h0, mul_if.o_busy}, 64'h0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (mul_if.o_done || mul_if.o_busy) dones++;
        end
        check("clrstart_no_op", 64'(dones), 64'h0);
        check_outputs_held("clrstart_hold");

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive_op(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
        @(posedge clk);                          // edge k
        #1 mul_if.i_start = 1'b0;
        @(posedge clk);
        @(posedge clk);                          // edge k+2
        #2 rst_n = 1'b0;
        #1;
        check("arst_lo_hi", {mul_if.o_rd_hi, mul_if.o_rd_lo}, 64'h0);
        check("arst_flags", {60'h0, mul_if.o_n, mul_if.o_z, mul_if.o_busy, mul_if.o_done}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst",  1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFF0, 32'h00001000, 32'h00000010);

        // Randomised operations
        for (int i = 0; i < 16; i++) begin
            logic [31:0] rs_r;
            rs_r = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 700)) : $urandom;
            do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, rs_r, $urandom, $urandom);
        end

        check("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
